one_counter_ctrl: RTL



---
 rtl/one_counter_pkg.sv | 26 ++
 rtl/one_counter_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/one_counter_pkg.sv
// Shared definitions for the ones-counter controller and datapath:
// ALU operation codes, controller state encoding and default register addresses.
package one_counter_pkg;

  typedef enum logic [3:0] {
    ALU_PASS = 4'h0,
    ALU_INC  = 4'h1,
    ALU_SHR  = 4'h2,
    ALU_ZERO = 4'h3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SCAN = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [3:0] R_DATA_DEF = 4'd0;
  localparam logic [3:0] R_CNT_DEF  = 4'd1;

  // A 16-bit word needs at most 16 shifts before it reaches zero.
  localparam logic [4:0] ITER_MAX = 5'd16;

endpackage

// File: rtl/one_counter_ctrl.sv
// Controller for the ones-counter: load word, shift-and-count until zero, load Out, pulse Done.
// Start-to-Done latency is n+4 cycles (n = highest set bit index + 1); Start is ignored while Busy.
module one_counter_ctrl
  import one_counter_pkg::*;
#(
  parameter logic [3:0] R_DATA = R_DATA_DEF,
  parameter logic [3:0] R_CNT  = R_CNT_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Start,
  input  logic [15:0] Datapath,
  output logic        IE,
  output logic [3:0]  WAA,
  output logic [3:0]  WAB,
  output logic [3:0]  RAA,
  output logic [3:0]  RAB,
  output logic        WEA,
  output logic        WEB,
  output logic        REA,
  output logic        REB,
  output logic [3:0]  S_ALU1,
  output logic [3:0]  S_ALU2,
  output logic        OE,
  output logic        Busy,
  output logic        Done
);

  state_e     state_q, state_d;
  logic [4:0] iter_q, iter_d;
  logic       scan_exit;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      iter_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // The iteration guard only matters if the datapath misbehaves; normally the word hits zero first.
  assign scan_exit = (Datapath == 16'h0000) || (iter_q >= ITER_MAX);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    IE      = 1'b0;
    WAA     = 4'd0;
    WAB     = 4'd0;
    RAA     = 4'd0;
    RAB     = 4'd0;
    WEA     = 1'b0;
    WEB     = 1'b0;
    REA     = 1'b0;
    REB     = 1'b0;
    S_ALU1  = ALU_PASS;
    S_ALU2  = ALU_PASS;
    OE      = 1'b0;
    Done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        IE      = 1'b1;
        WAB     = R_DATA;
        WEB     = 1'b1;
        WAA     = R_CNT;
        WEA     = 1'b1;
        S_ALU1  = ALU_ZERO;
        iter_d  = 5'd0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        RAB = R_DATA;
        REB = 1'b1;
        RAA = R_CNT;
        REA = 1'b1;
        if (scan_exit) begin
          state_d = ST_OUT;
        end else begin
          S_ALU1 = ALU_INC;
          WAA    = R_CNT;
          WEA    = Datapath[0];
          S_ALU2 = ALU_SHR;
          WAB    = R_DATA;
          WEB    = 1'b1;
          iter_d = iter_q + 5'd1;
        end
      end
      ST_OUT: begin
        RAA     = R_CNT;
        REA     = 1'b1;
        S_ALU1  = ALU_PASS;
        OE      = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy = (state_q != ST_IDLE);

endmodule
